// File: rtl/se_sram_master.sv
// se_sram_master: valid/ready client front-end for a single-port SRAM with
// byte write enables, one-cycle read latency and a 4-deep response FIFO.
// Ports: sram_clock, sram_reset (sync, active-high); req_* request channel;
// rsp_* in-order read response channel; busy (zero-fill engine running);
// sram_* registered SRAM request outputs and sram_read_data (SRAM data_out).
// Build option: define SE_SRAM_MASTER_CLEAR_EN to zero-fill the whole array
// after every reset before any client access is accepted.
module se_sram_master #(
    parameter int address_width = 14,
    parameter int data_width    = 32,
    localparam int be_width     = data_width / 8
) (
    input  logic                     sram_clock,
    input  logic                     sram_reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_read_not_write,
    input  logic [address_width-1:0] req_address,
    input  logic [data_width-1:0]    req_write_data,
    input  logic [be_width-1:0]      req_byte_enable,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [data_width-1:0]    rsp_data,
    output logic                     busy,
    output logic                     sram_select,
    output logic                     sram_read_not_write,
    output logic [address_width-1:0] sram_address,
    output logic [be_width-1:0]      sram_write_enable,
    output logic [data_width-1:0]    sram_write_data,
    input  logic [data_width-1:0]    sram_read_data
);

    logic                     run;
    logic                     accept;
    logic                     read_on_sram;
    logic                     read_pending_q;
    logic [2:0]               used;

    logic                     sel_d;
    logic                     rnw_d;
    logic [address_width-1:0] addr_d;
    logic [be_width-1:0]      we_d;
    logic [data_width-1:0]    wd_d;

    logic [data_width-1:0]    fifo_mem [4];
    logic [1:0]               wr_ptr_q;
    logic [1:0]               rd_ptr_q;
    logic [2:0]               count_q;
    logic                     push;
    logic                     pop;

`ifdef SE_SRAM_MASTER_CLEAR_EN
    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam logic [address_width-1:0] ADDR_ONE = 1;

    state_t                   state_q;
    state_t                   state_d;
    logic [address_width-1:0] clear_addr_q;
    logic                     clear_last;

    assign clear_last = (clear_addr_q == {address_width{1'b1}});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLEAR: if (clear_last) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge sram_clock) begin
        if (sram_reset) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR)
                clear_addr_q <= clear_addr_q + ADDR_ONE;
        end
    end

    assign run  = (state_q == ST_RUN);
    assign busy = (state_q == ST_CLEAR);
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // Every read in flight holds a FIFO slot from acceptance until it is
    // popped, so the FIFO can never overflow.
    assign read_on_sram = sram_select && sram_read_not_write;
    assign used = {2'b00, read_on_sram} + {2'b00, read_pending_q} + count_q;
    assign req_ready = run && !sram_reset && (used < 3'd4);
    assign accept = req_valid && req_ready;

    always_comb begin
        sel_d  = 1'b0;
        rnw_d  = 1'b1;
        addr_d = sram_address;
        we_d   = '0;
        wd_d   = sram_write_data;
`ifdef SE_SRAM_MASTER_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            sel_d  = 1'b1;
            rnw_d  = 1'b0;
            addr_d = clear_addr_q;
            we_d   = '1;
            wd_d   = '0;
        end else
`endif
        if (accept) begin
            sel_d  = 1'b1;
            rnw_d  = req_read_not_write;
            addr_d = req_address;
            we_d   = req_read_not_write ? '0 : req_byte_enable;
            wd_d   = req_write_data;
        end
    end

    always_ff @(posedge sram_clock) begin
        if (sram_reset) begin
            sram_select         <= 1'b0;
            sram_read_not_write <= 1'b1;
            sram_address        <= '0;
            sram_write_enable   <= '0;
            sram_write_data     <= '0;
            read_pending_q      <= 1'b0;
        end else begin
            sram_select         <= sel_d;
            sram_read_not_write <= rnw_d;
            sram_address        <= addr_d;
            sram_write_enable   <= we_d;
            sram_write_data     <= wd_d;
            read_pending_q      <= read_on_sram;
        end
    end

    // Read data is valid the cycle after the select; capture it then.
    assign push      = read_pending_q;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (count_q != 3'd0);
    assign rsp_data  = fifo_mem[rd_ptr_q];

    always_ff @(posedge sram_clock) begin
        if (sram_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < 4; i++)
                fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= sram_read_data;
                wr_ptr_q           <= wr_ptr_q + 2'd1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end

endmodule

// File: tb/tb_se_sram_master.sv
// Testbench for se_sram_master: SRAM model, per-cycle reference check of
// the request, SRAM and response sides, directed and random stimulus.
module tb_se_sram_master;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;
`ifdef SE_SRAM_MASTER_CLEAR_EN
    localparam int CLEAR_CYCLES = DEPTH;
`else
    localparam int CLEAR_CYCLES = 0;
`endif

    logic          sram_clock = 1'b0;
    logic          sram_reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_read_not_write = 1'b1;
    logic [AW-1:0] req_address = '0;
    logic [DW-1:0] req_write_data = '0;
    logic [BW-1:0] req_byte_enable = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic          sram_select;
    logic          sram_read_not_write;
    logic [AW-1:0] sram_address;
    logic [BW-1:0] sram_write_enable;
    logic [DW-1:0] sram_write_data;
    logic [DW-1:0] sram_read_data;

    se_sram_master #(
        .address_width(AW),
        .data_width(DW)
    ) dut (
        .sram_clock(sram_clock),
        .sram_reset(sram_reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_read_not_write(req_read_not_write),
        .req_address(req_address),
        .req_write_data(req_write_data),
        .req_byte_enable(req_byte_enable),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .busy(busy),
        .sram_select(sram_select),
        .sram_read_not_write(sram_read_not_write),
        .sram_address(sram_address),
        .sram_write_enable(sram_write_enable),
        .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data)
    );

    always #5 sram_clock = ~sram_clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'h9E37_79B9 * (i + 1) ^ 32'h5A5A_0F0F;
    endfunction

    // SRAM: byte-enable write, one-cycle-latency read.
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] sram_q = '0;
    bit            mem_init = 1'b0;
    assign sram_read_data = sram_q;

    always @(posedge sram_clock) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++)
                sram_mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (sram_select) begin
            if (sram_read_not_write)
                sram_q <= sram_mem[sram_address];
            else
                for (int b = 0; b < BW; b++)
                    if (sram_write_enable[b])
                        sram_mem[sram_address][8*b +: 8] <=
                            sram_write_data[8*b +: 8];
        end
    end

    // Reference: memory image updated at acceptance time, queue of
    // expected responses tagged with the cycle they were accepted in.
    typedef struct {
        logic [DW-1:0] data;
        int            t;
    } exp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          exp_q[$];
    logic [DW-1:0] got_q[$];
    int            cyc = 0;
    int            clear_left = 0;
    bit            nx_sel = 1'b0;
    logic          nx_rnw;
    logic [AW-1:0] nx_addr;
    logic [BW-1:0] nx_we;
    logic [DW-1:0] nx_wd;

    always @(negedge sram_clock) begin
        bit   ev;
        bit   busy_exp;
        exp_t e;
        if (cyc == 0)
            for (int i = 0; i < DEPTH; i++)
                ref_mem[i] = init_val(i);
        check("sram_select", sram_select, nx_sel);
        if (nx_sel) begin
            check("sram_rnw", sram_read_not_write, nx_rnw);
            check("sram_address", sram_address, nx_addr);
            check("sram_we", sram_write_enable, nx_we);
            if (!nx_rnw)
                check("sram_wdata", sram_write_data, nx_wd);
        end
        ev = (exp_q.size() > 0) && (cyc >= exp_q[0].t + 3);
        check("rsp_valid", rsp_valid, ev);
        if (ev)
            check("rsp_data", rsp_data, exp_q[0].data);
        nx_sel = 1'b0;
        if (sram_reset) begin
            check("req_ready_in_reset", req_ready, 1'b0);
            exp_q.delete();
            clear_left = CLEAR_CYCLES;
        end else begin
            busy_exp = (clear_left > 0);
            check("busy", busy, busy_exp);
            check("req_ready", req_ready,
                  !busy_exp && (exp_q.size() < 4));
            if (ev && rsp_ready) begin
                got_q.push_back(rsp_data);
                void'(exp_q.pop_front());
            end
            if (busy_exp) begin
                nx_sel  = 1'b1;
                nx_rnw  = 1'b0;
                nx_addr = AW'(DEPTH - clear_left);
                nx_we   = '1;
                nx_wd   = '0;
                ref_mem[nx_addr] = '0;
                clear_left--;
            end else if (req_valid && req_ready) begin
                nx_sel  = 1'b1;
                nx_rnw  = req_read_not_write;
                nx_addr = req_address;
                nx_we   = req_read_not_write ? '0 : req_byte_enable;
                nx_wd   = req_write_data;
                if (req_read_not_write) begin
                    e.data = ref_mem[req_address];
                    e.t    = cyc;
                    exp_q.push_back(e);
                end else begin
                    for (int b = 0; b < BW; b++)
                        if (req_byte_enable[b])
                            ref_mem[req_address][8*b +: 8] =
                                req_write_data[8*b +: 8];
                end
            end
        end
        cyc++;
    end

    // Drive one request and hold it until accepted; returns #1 after the
    // accepting edge.
    task automatic issue(input logic rnw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        int n = 0;
        req_valid          = 1'b1;
        req_read_not_write = rnw;
        req_address        = a;
        req_write_data     = d;
        req_byte_enable    = be;
        @(negedge sram_clock);
        while (!req_ready && n < 60) begin
            @(negedge sram_clock);
            n++;
        end
        if (!req_ready)
            check("issue_timeout", 1'b0, 1'b1);
        @(posedge sram_clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        rsp_ready = 1'b1;
        while (got_q.size() < n && k < 60) begin
            @(posedge sram_clock);
            #1;
            k++;
        end
        if (got_q.size() < n)
            check("rsp_timeout", got_q.size(), n);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge sram_clock);
            #1;
        end
    endtask

    initial begin
        int base;
        int cnt;
        int cnt2;
        repeat (2) @(posedge sram_clock);
        #1;
        check("rst_select", sram_select, 1'b0);
        check("rst_rnw", sram_read_not_write, 1'b1);
        check("rst_address", sram_address, 0);
        check("rst_we", sram_write_enable, 0);
        check("rst_wdata", sram_write_data, 0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 0);
        @(posedge sram_clock);
        #1;
        sram_reset = 1'b0;

`ifdef SE_SRAM_MASTER_CLEAR_EN
        cnt = 0;
        cnt2 = 0;
        base = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sram_clock);
            if (busy)
                cnt++;
            if (sram_select)
                cnt2++;
            if (sram_select && !sram_read_not_write &&
                sram_address == AW'(base) && sram_write_enable == 4'hF &&
                sram_write_data == 0)
                base++;
        end
        check("clear_busy_cycles", cnt, 16);
        check("clear_selects", cnt2, 16);
        check("clear_ordered_writes", base, 16);
        check("clear_then_ready", req_ready, 1'b1);
        @(posedge sram_clock);
        #1;
        base = got_q.size();
        issue(1'b1, 4'd9, '0, '0);
        wait_rsp(base + 1);
        if (got_q.size() > base)
            check("clear_read9", got_q[base], 0);
`else
        @(negedge sram_clock);
        check("first_busy", busy, 1'b0);
        check("first_ready", req_ready, 1'b1);
        @(posedge sram_clock);
        #1;
`endif

        // basic write/read with exact latency
        rsp_ready = 1'b1;
        issue(1'b0, 4'd5, 32'h1234_5678, 4'hF);
        base = got_q.size();
        issue(1'b1, 4'd5, '0, '0);
        @(posedge sram_clock);
        #1;
        check("lat_edge1", rsp_valid, 1'b0);
        @(posedge sram_clock);
        #1;
        check("lat_edge2", rsp_valid, 1'b1);
        check("basic_data", rsp_data, 32'h1234_5678);
        wait_rsp(base + 1);
        if (got_q.size() > base)
            check("basic_got", got_q[base], 32'h1234_5678);

        // byte enables, and a zero-enable write that must change nothing
        issue(1'b0, 4'd7, 32'hAABB_CCDD, 4'hF);
        issue(1'b0, 4'd7, 32'h1122_3344, 4'b0101);
        issue(1'b0, 4'd7, 32'hFFFF_FFFF, 4'b0000);
        base = got_q.size();
        issue(1'b1, 4'd7, '0, '0);
        wait_rsp(base + 1);
        if (got_q.size() > base)
            check("byte_enable", got_q[base], 32'hAA22_CC44);

        // streaming reads
        for (int i = 0; i < 8; i++)
            issue(1'b0, AW'(i), DW'(i), 4'hF);
        base = got_q.size();
        cnt = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_read_not_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_address = AW'(i);
            @(negedge sram_clock);
            if (!req_ready)
                cnt++;
            @(posedge sram_clock);
            #1;
        end
        req_valid = 1'b0;
        check("stream_ready_drops", cnt, 0);
        wait_rsp(base + 8);
        for (int i = 0; i < 8; i++)
            if (got_q.size() > base + i)
                check("stream_data", got_q[base+i], i);

        // back-pressure: four credits
        rsp_ready = 1'b0;
        base = got_q.size();
        cnt = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_address = AW'(i);
            @(negedge sram_clock);
            if (req_ready)
                cnt++;
            @(posedge sram_clock);
            #1;
        end
        req_valid = 1'b0;
        check("bp_accepted", cnt, 4);
        @(negedge sram_clock);
        check("bp_ready_low", req_ready, 1'b0);
        @(posedge sram_clock);
        #1;
        wait_rsp(base + 4);
        cycles(6);
        check("bp_count", got_q.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (got_q.size() > base + i)
                check("bp_data", got_q[base+i], i);
        @(negedge sram_clock);
        check("bp_ready_back", req_ready, 1'b1);
        @(posedge sram_clock);
        #1;

        // reset with three reads in flight
        rsp_ready = 1'b0;
        issue(1'b1, 4'd1, '0, '0);
        issue(1'b1, 4'd2, '0, '0);
        issue(1'b1, 4'd3, '0, '0);
        base = got_q.size();
        sram_reset = 1'b1;
        @(posedge sram_clock);
        #1;
        sram_reset = 1'b0;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_select", sram_select, 1'b0);
        rsp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid)
                cnt++;
            @(posedge sram_clock);
            #1;
        end
        check("midrst_stale", cnt, 0);
        check("midrst_got", got_q.size() - base, 0);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            req_valid          = ($urandom_range(0, 3) != 0);
            req_read_not_write = $urandom_range(0, 1) == 1;
            req_address        = AW'($urandom_range(0, DEPTH - 1));
            req_write_data     = $urandom;
            req_byte_enable    = BW'($urandom_range(0, 15));
            rsp_ready          = ($urandom_range(0, 3) != 0);
            @(posedge sram_clock);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cycles(10);
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/se_sram_master.md
# se_sram_master

Initiator-side controller that drives the single-port SRAM request interface (select, read_not_write, address, byte write_enable, write_data) and collects its one-cycle-latency data_out. Accepts client requests on a valid/ready channel and returns read data on a valid/ready response channel. A 4-entry response FIFO absorbs back-pressure so no read data is lost. An optional start-of-day engine zero-fills the whole array. The block sits between a CPU or DMA client and a `se_sram_srw_*_we8`-class memory.

## Interface
Parameters:
- address_width, 14, SRAM word-address width.
- data_width, 32, word width; must be a multiple of 8; be_width = data_width/8.

Ports:
- sram_clock  in  1  sole clock; SRAM shares it, SRAM clock enable tied high.
- sram_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  client request present.
- req_ready  out  1  request accepted at a rising edge when req_valid && req_ready.
- req_read_not_write  in  1  1 = read, 0 = write.
- req_address  in  address_width  word address.
- req_write_data  in  data_width  write data.
- req_byte_enable  in  be_width  per-byte write enable; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  response consumed at a rising edge when rsp_valid && rsp_ready.
- rsp_data  out  data_width  read data, in request order.
- busy  out  1  clear engine running.
- sram_select  out  1  SRAM select.
- sram_read_not_write  out  1  SRAM read_not_write.
- sram_address  out  address_width  SRAM address.
- sram_write_enable  out  be_width  SRAM byte write enables.
- sram_write_data  out  data_width  SRAM write data.
- sram_read_data  in  data_width  SRAM data_out; valid the cycle after a read select.

## Operation
- States:
  - CLEAR: only when the macro is compiled in.
  - RUN.
- Reset drives all state as follows:
  - With the macro, the block enters CLEAR; without it, RUN.
  - All SRAM-side outputs are registered. Reset values: sram_select 0, sram_read_not_write 1, sram_address 0, sram_write_enable 0, sram_write_data 0.
  - rsp_valid 0, rsp_data 0.
  - FIFO empty; pending-read flags cleared.
- RUN, request accept: an accepted request is registered onto the SRAM outputs the next cycle for exactly one cycle, with sram_select = 1. Otherwise sram_select = 0.
- Writes:
  - sram_write_enable = req_byte_enable; sram_read_not_write = 0.
  - No response is generated.
  - A write with byte enable 0 still issues a select; memory is unchanged.
- Reads:
  - sram_write_enable = 0; sram_read_not_write = 1.
  - A pending flag tracks the read to the capture cycle, when sram_read_data is pushed into the FIFO.
- Credit rule:
  - used = (read on SRAM outputs) + (read pending capture) + FIFO count.
  - req_ready = RUN && !sram_reset && used < 4. This is independent of req_read_not_write and of rsp_ready.
- Ordering: strictly in order. rsp_valid = FIFO non-empty; rsp_data = FIFO head.
- FIFO simultaneous push and pop: count is unchanged. The FIFO never overflows; overflow is unreachable by the credit rule.
- CLEAR:
  - busy = 1 and req_ready = 0.
  - Issues one write per cycle: address 0 to 2^address_width-1, data 0, all byte enables set.
  - After the write of the last address, the block enters RUN. busy falls in the same cycle that req_ready may first rise.
- Reset mid-operation: in-flight reads are discarded, the FIFO is flushed, and no response is emitted for them. With the macro, CLEAR restarts from address 0.

## Timing
- Read accepted at edge E:
  - SRAM select is high during cycle E+1.
  - Data is captured into the FIFO at edge E+2.
  - rsp_valid is high from cycle E+3 (latency 3), assuming an empty FIFO.
- Write accepted at edge E: SRAM writes at the end of cycle E+1.
- With rsp_ready held high, sustained throughput is one request per cycle.
- With rsp_ready low, at most 4 reads are outstanding.
- Clear duration: 2^address_width cycles with busy high, beginning the cycle after reset deasserts.

## Configuration
- SE_SRAM_MASTER_CLEAR_EN defined: CLEAR state and address counter are present. The memory is zero-filled after every reset before any client access.
- SE_SRAM_MASTER_CLEAR_EN undefined: no CLEAR state. busy is tied 0, and req_ready may rise the first cycle after reset deasserts. Memory contents are whatever the SRAM initialises to.

## Test plan
- Clear: macro on, address_width=4, reset pulse → busy high for 16 cycles; 16 selects, addresses 0..15, write_enable 4'hF, data 0; then req_ready=1 and a read of address 9 returns 0.
- Basic: write 0x12345678 to address 5, then read address 5 → rsp_data 0x12345678, rsp_valid exactly 3 cycles after read acceptance.
- Byte enables: write 0xAABBCCDD to address 7 (be 4'hF), then write 0x11223344 to address 7 with be 4'b0101, then read address 7 → 0xAA22CC44.
- Streaming: 8 back-to-back reads of addresses 0..7 preloaded with value = address, rsp_ready high → req_ready never drops; 8 consecutive responses 0..7 in order.
- Back-pressure: rsp_ready=0, req_valid held with reads → exactly 4 accepted, then req_ready=0. Raise rsp_ready → 4 responses in order, none lost or duplicated, and req_ready returns to 1.
- Reset mid-flight: 3 reads outstanding, assert sram_reset for 1 cycle → rsp_valid=0 and sram_select=0 after reset; no stale response ever appears.
